// File: rtl/dmem_arbiter_ctrl.sv
`timescale 1ns/1ps
// dmem_arbiter_ctrl
//   Round-robin arbiter and byte sequencer for a byte-wide, big-endian data
//   memory. Two requesters (port 0 CPU, port 1 debug/DMA) issue byte, half or
//   word accesses. A granted access is checked for size legality, alignment
//   and bounds, then run one memory byte per clock, MSB at the lowest address.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   reqN_i, rwN_i, sizeN_i     request, 1=write, 00 byte/01 half/10 word/11 bad
//   addrN_i, wdataN_i          byte address, right-justified store data
//   ackN_o, errN_o             one-cycle completion pulse, error flag with ack
//   rdataN_o                   load data, right-justified, zero-extended
//   mem_addr_o, mem_we_o       memory byte address, byte write strobe
//   mem_wdata_o, mem_rdata_i   byte to write, byte read (combinational)
//
// state | meaning
// IDLE  | waiting for a request; grant, latch fields, check legality
// XFER  | one memory byte per cycle, cnt_q bytes still to go after this one
// DONE  | ack to the granted port, load data visible on its rdata
// ERR   | ack + err to the granted port, no memory traffic
module dmem_arbiter_ctrl #(
   parameter int ADDR_W    = 9,
   parameter int MEM_BYTES = 401
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_i,
   input  logic              req1_i,
   input  logic              rw0_i,
   input  logic              rw1_i,
   input  logic [1:0]        size0_i,
   input  logic [1:0]        size1_i,
   input  logic [31:0]       addr0_i,
   input  logic [31:0]       addr1_i,
   input  logic [31:0]       wdata0_i,
   input  logic [31:0]       wdata1_i,
   output logic              ack0_o,
   output logic              ack1_o,
   output logic              err0_o,
   output logic              err1_o,
   output logic [31:0]       rdata0_o,
   output logic [31:0]       rdata1_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [7:0]        mem_wdata_o,
   input  logic [7:0]        mem_rdata_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   state_t            state_q, state_d;

   logic              last_gnt_q;
   logic              port_q;
   logic              rw_q;
   logic [1:0]        cnt_q;
   logic [31:0]       wsh_q;
   logic [31:0]       acc_q;
   logic [31:0]       rdata0_q;
   logic [31:0]       rdata1_q;
   logic [ADDR_W-1:0] mem_addr_q;

   logic              gnt_valid;
   logic              gnt_port;
   logic              sel_rw;
   logic [1:0]        sel_size;
   logic [31:0]       sel_addr;
   logic [31:0]       sel_wdata;
   logic [2:0]        sel_k;
   logic [32:0]       end_addr;
   logic              bad_req;
   logic [31:0]       acc_d;

   // On a tie the port that did not win last time gets the grant.
   always_comb begin
      gnt_valid = req0_i | req1_i;
      if (req0_i && req1_i) gnt_port = ~last_gnt_q;
      else                  gnt_port = req1_i;
      sel_rw    = gnt_port ? rw1_i    : rw0_i;
      sel_size  = gnt_port ? size1_i  : size0_i;
      sel_addr  = gnt_port ? addr1_i  : addr0_i;
      sel_wdata = gnt_port ? wdata1_i : wdata0_i;
   end

   // Bounds check uses a 33-bit sum so addresses near 2^32 cannot wrap legal.
   always_comb begin
      sel_k = 3'd0;
      case (sel_size)
         2'b00:   sel_k = 3'd1;
         2'b01:   sel_k = 3'd2;
         2'b10:   sel_k = 3'd4;
         default: sel_k = 3'd0;
      endcase
      end_addr = {1'b0, sel_addr} + {30'd0, sel_k};
      bad_req  = (sel_size == 2'b11)
               | ((sel_size == 2'b01) && sel_addr[0])
               | ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00))
               | (end_addr > 33'(MEM_BYTES));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (gnt_valid) state_d = bad_req ? ST_ERR : ST_XFER;
         ST_XFER: if (cnt_q == 2'd0) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // The write strobe is also gated by reset so the byte in flight when reset
   // arrives is not committed on the aborting edge.
   always_comb begin
      ack0_o      = 1'b0;
      ack1_o      = 1'b0;
      err0_o      = 1'b0;
      err1_o      = 1'b0;
      mem_we_o    = 1'b0;
      mem_wdata_o = 8'h00;
      case (state_q)
         ST_XFER: begin
            if (rw_q && !rst_i) begin
               mem_we_o    = 1'b1;
               mem_wdata_o = wsh_q[31:24];
            end
         end
         ST_DONE: begin
            ack0_o = ~port_q;
            ack1_o = port_q;
         end
         ST_ERR: begin
            ack0_o = ~port_q;
            ack1_o = port_q;
            err0_o = ~port_q;
            err1_o = port_q;
         end
         default: ;
      endcase
      mem_addr_o = mem_addr_q;
      rdata0_o   = rdata0_q;
      rdata1_o   = rdata1_q;
      acc_d      = {acc_q[23:0], mem_rdata_i};
   end

   // Store data is pre-aligned so the MSB of the access sits in [31:24] and
   // each XFER cycle shifts the next byte up.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_gnt_q <= 1'b1;
         port_q     <= 1'b0;
         rw_q       <= 1'b0;
         cnt_q      <= 2'd0;
         wsh_q      <= 32'h0;
         acc_q      <= 32'h0;
         rdata0_q   <= 32'h0;
         rdata1_q   <= 32'h0;
         mem_addr_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (gnt_valid) begin
                  port_q     <= gnt_port;
                  last_gnt_q <= gnt_port;
                  rw_q       <= sel_rw;
                  acc_q      <= 32'h0;
                  case (sel_size)
                     2'b00: begin
                        cnt_q <= 2'd0;
                        wsh_q <= {sel_wdata[7:0], 24'h0};
                     end
                     2'b01: begin
                        cnt_q <= 2'd1;
                        wsh_q <= {sel_wdata[15:0], 16'h0};
                     end
                     default: begin
                        cnt_q <= 2'd3;
                        wsh_q <= sel_wdata;
                     end
                  endcase
                  if (!bad_req) mem_addr_q <= sel_addr[ADDR_W-1:0];
               end
            end
            ST_XFER: begin
               acc_q <= acc_d;
               wsh_q <= {wsh_q[23:0], 8'h00};
               if (cnt_q != 2'd0) begin
                  cnt_q      <= cnt_q - 2'd1;
                  mem_addr_q <= mem_addr_q + ADDR_W'(1);
               end else if (!rw_q) begin
                  if (port_q) rdata1_q <= acc_d;
                  else        rdata0_q <= acc_d;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
